// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types and constants for the writeback stage.
// Holds the result-select encoding, the load funct3 codes and small
// sign-extension helpers used by the load extractor.
package riscv_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic [31:0] sext8(input logic [7:0] value);
        return {{24{value[7]}}, value};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational load-data extractor: picks the addressed byte/half/word
// out of the aligned memory word, sign- or zero-extends it, and flags
// loads whose address is not naturally aligned for their size.
module load_ext
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    input  logic        i_is_load,
    output logic [31:0] o_data,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_halfLoad;
    logic        w_wordLoad;

    // Select the addressed byte and half-word lanes from the memory word
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_offset)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Extend the selected lane by load size; unlisted codes return the word
    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = sext8(w_byte);
            F3_LH:   o_data = sext16(w_half);
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

    assign w_halfLoad   = (i_funct3 == F3_LH) || (i_funct3 == F3_LHU);
    assign w_wordLoad   = (i_funct3 == F3_LW);
    assign o_misaligned = i_is_load &&
                          ((w_halfLoad && i_offset[0]) ||
                           (w_wordLoad && (i_offset != 2'b00)));

endmodule

// File: rtl/wb_stage.sv
// Writeback pipeline stage: the W register, result selection and the
// register-file write port (also the forwarding source).
// Optional feature: define WB_INSTRET_EN to add the 64-bit instret counter.
module wb_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_valid,
    input  logic        m_reg_write,
    input  logic [4:0]  m_rd,
    input  logic [1:0]  m_result_src,
    input  logic [31:0] m_alu_result,
    input  logic [31:0] m_pc_plus4,
    input  logic [31:0] m_rdata,
    input  logic [2:0]  m_funct3,
    input  logic        stall_w,
    input  logic        flush_w,
    output logic        we3,
    output logic [4:0]  a3,
    output logic [31:0] wd3,
    output logic        w_valid,
    output logic        load_misalign
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0] instret
`endif
);

    logic        r_valid;
    logic        r_regWrite;
    logic [4:0]  r_rd;
    logic [1:0]  r_resultSrc;
    logic [31:0] r_aluResult;
    logic [31:0] r_pcPlus4;
    logic [31:0] r_rdata;
    logic [2:0]  r_funct3;

    logic [31:0] w_loadData;
    logic        w_misaligned;
    logic        w_commit;

    // W register: capture on unstalled edges; flush kills validity even when stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_regWrite  <= 1'b0;
            r_rd        <= 5'd0;
            r_resultSrc <= 2'd0;
            r_aluResult <= 32'd0;
            r_pcPlus4   <= 32'd0;
            r_rdata     <= 32'd0;
            r_funct3    <= 3'd0;
        end else begin
            if (!stall_w) begin
                r_regWrite  <= m_reg_write;
                r_rd        <= m_rd;
                r_resultSrc <= m_result_src;
                r_aluResult <= m_alu_result;
                r_pcPlus4   <= m_pc_plus4;
                r_rdata     <= m_rdata;
                r_funct3    <= m_funct3;
            end
            if (flush_w) begin
                r_valid <= 1'b0;
            end else if (!stall_w) begin
                r_valid <= m_valid;
            end
        end
    end

    load_ext u_load_ext (
        .i_rdata      (r_rdata),
        .i_offset     (r_aluResult[1:0]),
        .i_funct3     (r_funct3),
        .i_is_load    (r_resultSrc == RES_LOAD),
        .o_data       (w_loadData),
        .o_misaligned (w_misaligned)
    );

    // Result mux straight off the W register so forwarding sees it this cycle
    always_comb begin
        wd3 = r_aluResult;
        case (r_resultSrc)
            RES_LOAD: wd3 = w_loadData;
            RES_PC4:  wd3 = r_pcPlus4;
            default:  wd3 = r_aluResult;
        endcase
    end

    assign w_commit      = r_valid & ~stall_w;
    assign w_valid       = r_valid;
    assign a3            = r_rd;
    assign load_misalign = w_commit & w_misaligned;
    assign we3           = w_commit & r_regWrite & (r_rd != 5'd0) & ~w_misaligned;

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    // Count every instruction leaving W, including rd=0 and misaligned loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= 64'd0;
        end else if (w_commit) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`endif

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 m_valid  in  1  MEM stage holds a valid instruction.
REQ-004 m_reg_write  in  1  instruction writes rd.
REQ-005 m_rd  in  5  destination register index.
REQ-006 m_result_src  in  2  result select (result_src_t).
REQ-007 m_alu_result  in  32  ALU result / load effective address.
REQ-008 m_pc_plus4  in  32  PC+4 for JAL/JALR link.
REQ-009 m_rdata  in  32  raw aligned data-memory word.
REQ-010 m_funct3  in  3  load size/sign code.
REQ-011 stall_w  in  1  hold W register, block commit.
REQ-012 flush_w  in  1  kill the instruction entering W.
REQ-013 we3 / a3 / wd3  out  1/5/32  regfile write port, also the forwarding source.
REQ-014 w_valid  out  1  W register holds a valid instruction.
REQ-015 load_misalign  out  1  W holds a misaligned load; pulses for the commit cycle.
REQ-016 instret  out  64  retired-instruction count (only with WB_INSTRET_EN).

Function
REQ-017 W register SHALL capture all m_* fields on a rising edge when stall_w=0; contents SHALL be held when stall_w=1.
REQ-018 flush_w=1 SHALL clear w_valid at the next edge, taking priority over stall_w.
REQ-019 Result select: RES_ALU(0) -> alu_result; RES_LOAD(1) -> extracted load; RES_PC4(2) -> pc_plus4; 3 (reserved) -> alu_result.
REQ-020 Load extraction SHALL use the registered alu_result[1:0] as byte offset.
- LB(000): sign-extended byte.
- LH(001): sign-extended half at offset[1].
- LW(010), and 011/110/111: full word.
- LBU(100) / LHU(101): zero-extended.
REQ-021 Misaligned: RES_LOAD with LH/LHU and offset[0]=1, or LW with offset!=0.
- load_misalign=1 while w_valid=1 and stall_w=0.
- Write suppressed.
REQ-022 we3 = w_valid & reg_write & (rd!=0) & ~stall_w & ~misaligned; a3 = registered rd; wd3 = selected result.
- wd3 is combinational from W register; zero added latency.
- Regfile commits at the next edge.
REQ-023 A stalled instruction SHALL commit exactly once, in the first cycle stall_w=0.
REQ-024 rd=0 instructions SHALL retire and count, but never assert we3.

Reset
REQ-025 rst_n low SHALL immediately force w_valid=0, we3=0, load_misalign=0, instret=0, a3=0, wd3=0; data fields need not reset.
REQ-026 Reset asserted mid-stall SHALL discard the held instruction; no commit after release.

Configuration
REQ-027 Macro WB_INSTRET_EN.
- Defined: instret port present; increments by 1 at each edge where w_valid=1 and stall_w=0 (misaligned loads included); wraps 2^64-1 -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Structure
REQ-028 riscv_pkg SHALL hold result_src_t (RES_ALU, RES_LOAD, RES_PC4) and the load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
REQ-029 Load extraction and the misalign check SHALL be a combinational sub-module load_ext.

Verification
REQ-030 LB, rdata=0x80FF_7F01, addr[1:0]=3 -> wd3=0xFFFF_FF80, we3=1 one cycle; LBU at offset 0 -> 0x0000_0001.
REQ-031 LH at offset 2, rdata=0x8001_1234 -> wd3=0xFFFF_8001; LH at offset 1 -> load_misalign=1, we3=0.
REQ-032 RES_PC4, pc_plus4=0x0000_0104, rd=1 -> a3=1, wd3=0x104; same instruction with rd=0 -> we3=0, instret +1.
REQ-033 Stall of 3 cycles on an ALU write of 0x1234_5678 to x5 -> we3 low during stall, high exactly one cycle after release; instret +1 only.
REQ-034 flush_w with stall_w both high at a capture edge -> w_valid=0 next cycle, no write.
REQ-035 rst_n dropped mid-cycle with we3=1 -> we3 and w_valid go 0 without a clock edge; instret reads 0.
